line_clear_engine: RTL and testbench

- Sequential line-clear stage for the Tetris playfield. It consumes the highest-full-row index produced by the first_high_index priority encoder, which it instantiates internally.
- On start it latches a snapshot of the board. It then removes full rows one per cycle, highest first, shifting the rows above each cleared row down by one.
- When no full rows remain it reports the cleared board, the number of lines removed and the score increment to the game controller.

---
 rtl/line_clear_engine.sv | 119 +++++++++++
 tb/tb_line_clear_engine.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/line_clear_engine.sv
// Sequential Tetris line-clear stage: snapshots a board, removes full rows
// highest-first one per cycle, then reports the cleared board and the score.

module first_high_index (
    input  logic [19:0] req,
    output logic [4:0]  idx
);
    // Ascending scan, so the highest set bit wins; 20 means no bit is set.
    always_comb begin
        idx = 5'd20;
        for (int i = 0; i < 20; i++) begin
            if (req[i]) idx = i[4:0];
        end
    end
endmodule

module line_clear_engine #(
    parameter int COLS    = 10,
    parameter int SCORE_W = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [20*COLS-1:0]   board_in,
    output logic                 busy,
    output logic                 done,
    output logic [20*COLS-1:0]   board_out,
    output logic [4:0]           lines_cleared,
    output logic [SCORE_W-1:0]   score_delta
);
    localparam int ROWS = 20;
    localparam logic [4:0] NONE = 5'd20;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [ROWS*COLS-1:0]    board_reg;
    logic [ROWS*COLS-1:0]    shifted;
    logic [ROWS-1:0]         full_rows;
    logic [4:0]              idx;
    logic [4:0]              count_reg;
    logic [4:0]              lines_reg;
    logic [SCORE_W-1:0]      score_reg;

    // Row idx and everything above it drop by one; row 19 refills with empty cells.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            assign full_rows[gi] = &board_reg[gi*COLS +: COLS];
            if (gi == ROWS - 1) begin : g_top
                assign shifted[gi*COLS +: COLS] =
                    (idx <= 5'(gi)) ? '0 : board_reg[gi*COLS +: COLS];
            end else begin : g_mid
                assign shifted[gi*COLS +: COLS] =
                    (idx <= 5'(gi)) ? board_reg[(gi+1)*COLS +: COLS]
                                    : board_reg[gi*COLS +: COLS];
            end
        end
    endgenerate

    first_high_index u_enc (
        .req (full_rows),
        .idx (idx)
    );

    function automatic logic [SCORE_W-1:0] score_for(input logic [4:0] n);
        case (n)
            5'd0:    score_for = '0;
            5'd1:    score_for = SCORE_W'(40);
            5'd2:    score_for = SCORE_W'(100);
            5'd3:    score_for = SCORE_W'(300);
            default: score_for = SCORE_W'(1200);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (idx == NONE) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            board_reg <= '0;
            count_reg <= '0;
            lines_reg <= '0;
            score_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: if (start) begin
                    board_reg <= board_in;
                    count_reg <= '0;
                end
                SCAN: if (idx != NONE) begin
                    board_reg <= shifted;
                    count_reg <= count_reg + 5'd1;
                end else begin
                    lines_reg <= count_reg;
                    score_reg <= score_for(count_reg);
                end
                default: ;
            endcase
        end
    end

    assign busy          = (state_reg != IDLE);
    assign done          = (state_reg == DONE);
    assign board_out     = board_reg;
    assign lines_cleared = lines_reg;
    assign score_delta   = score_reg;
endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine: table of boards with hand-computed
// results, plus sequences for ignored starts and reset mid-pass.

module tb_line_clear_engine;
    localparam int COLS = 10;
    localparam int SW   = 11;
    localparam int BW   = 20 * COLS;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [BW-1:0] board_in;
    logic          busy;
    logic          done;
    logic [BW-1:0] board_out;
    logic [4:0]    lines_cleared;
    logic [SW-1:0] score_delta;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string         name;
        logic [BW-1:0] board;
        logic [BW-1:0] exp_board;
        int            exp_lines;
        int            exp_score;
        int            exp_lat;
    } vec_t;

    vec_t vecs[6];

    line_clear_engine #(.COLS(COLS), .SCORE_W(SW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .board_in      (board_in),
        .busy          (busy),
        .done          (done),
        .board_out     (board_out),
        .lines_cleared (lines_cleared),
        .score_delta   (score_delta)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] row(input int r, input logic [COLS-1:0] v);
        logic [BW-1:0] b;
        b = '0;
        b[r*COLS +: COLS] = v;
        return b;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; starts a pass, optionally re-pulses start at cycle poke,
    // and returns at the negedge where done is first seen (or on timeout).
    task automatic run_pass(input string name, input logic [BW-1:0] b, input int poke,
                            input logic [BW-1:0] exp_board, input int exp_lines,
                            input int exp_score, input int exp_lat);
        int lat;
        start    = 1'b1;
        board_in = b;
        @(negedge clk);
        board_in = ~b;
        lat      = 1;
        start    = (poke == 1);
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            start = (lat == poke) && (done !== 1'b1);
        end
        start = 1'b0;
        chk({name, " done_seen"}, 256'(done), 256'(1));
        chk({name, " latency"}, 256'(lat), 256'(exp_lat));
        chk({name, " lines"}, 256'(lines_cleared), 256'(exp_lines));
        chk({name, " score"}, 256'(score_delta), 256'(exp_score));
        chk({name, " board"}, 256'(board_out), 256'(exp_board));
        $display("pass %s: lines=%0d score=%0d latency=%0d", name, lines_cleared, score_delta, lat);
    endtask

    initial begin
        logic [BW-1:0] full3;
        logic [COLS-1:0] ones;
        ones  = '1;
        full3 = row(0, ones) | row(1, ones) | row(2, ones);

        vecs[0] = '{"empty", '0, '0, 0, 0, 2};
        vecs[1] = '{"one_row", row(0, ones) | row(1, 10'b0000000001),
                    row(0, 10'b0000000001), 1, 40, 3};
        vecs[2] = '{"two_rows", row(3, ones) | row(5, ones) | row(4, 10'b1010101010) | row(6, 10'b0000000011),
                    row(3, 10'b1010101010) | row(4, 10'b0000000011), 2, 100, 4};
        vecs[3] = '{"three_rows", row(2, ones) | row(8, ones) | row(9, ones) | row(10, 10'b1111100000),
                    row(7, 10'b1111100000), 3, 300, 5};
        vecs[4] = '{"four_rows", row(0, ones) | row(1, ones) | row(2, ones) | row(3, ones) | row(19, 10'b1),
                    row(15, 10'b1), 4, 1200, 6};
        vecs[5] = '{"all_ones", '1, '0, 20, 1200, 22};

        reset    = 1'b1;
        start    = 1'b0;
        board_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 256'(busy), 256'(0));
        chk("reset done", 256'(done), 256'(0));
        chk("reset board", 256'(board_out), 256'(0));
        chk("reset lines", 256'(lines_cleared), 256'(0));
        chk("reset score", 256'(score_delta), 256'(0));
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_pass(vecs[i].name, vecs[i].board, 0, vecs[i].exp_board,
                     vecs[i].exp_lines, vecs[i].exp_score, vecs[i].exp_lat);
            @(negedge clk);
            chk({vecs[i].name, " done_pulse"}, 256'(done), 256'(0));
            chk({vecs[i].name, " idle"}, 256'(busy), 256'(0));
            repeat (3) @(negedge clk);
            chk({vecs[i].name, " hold_lines"}, 256'(lines_cleared), 256'(vecs[i].exp_lines));
            chk({vecs[i].name, " hold_score"}, 256'(score_delta), 256'(vecs[i].exp_score));
        end

        // start mid-pass (cycle 3) and again in the done cycle; both must be ignored
        run_pass("ignore_start", full3, 3, '0, 3, 300, 5);
        start    = 1'b1;
        board_in = '1;
        @(negedge clk);
        chk("done_cycle_start busy", 256'(busy), 256'(0));
        chk("done_cycle_start lines", 256'(lines_cleared), 256'(3));
        chk("done_cycle_start board", 256'(board_out), 256'(0));
        run_pass("restart_idle", row(4, 10'b0000011111), 0, row(4, 10'b0000011111), 0, 0, 2);
        @(negedge clk);

        // leave nonzero results, then abort a pass with reset
        run_pass("pre_abort", full3, 0, '0, 3, 300, 5);
        @(negedge clk);
        start    = 1'b1;
        board_in = full3 | row(5, 10'b1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort busy", 256'(busy), 256'(0));
        chk("abort board", 256'(board_out), 256'(0));
        chk("abort lines", 256'(lines_cleared), 256'(0));
        chk("abort score", 256'(score_delta), 256'(0));
        reset = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (30) begin
                @(negedge clk);
                if (done === 1'b1) seen++;
            end
            chk("abort no_done", 256'(seen), 256'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
